// File: rtl/mini_alu_core_if.sv
// rtl/mini_alu_core_if.sv - port bundle between mini_alu_core and its ROM/LCD/LED surroundings
//
// Purpose: groups the instruction fetch, LCD byte handshake, LED and status
// signals of mini_alu_core. The core connects through modport master; the
// environment (ROM, LCD controller, board) uses modport slave.
//
// Signals:
//   iEnable    core may fetch (low stalls at FETCH)
//   oIAddr     instruction address (= IP)
//   iInstr     instruction {op[3:0], dst, src1, src0}, combinational ROM read
//   oLed       LED register
//   oLcdValid  LCD byte valid
//   oLcdData   LCD byte
//   iLcdReady  LCD accepts byte
//   oFault     sticky stack overflow/underflow flag
//   oRetire    one-cycle pulse per completed instruction
interface mini_alu_core_if #(
  parameter int ADDR_W = 16,
  parameter int REG_AW = 8
);
  logic                    iEnable;
  logic [ADDR_W-1:0]       oIAddr;
  logic [4+3*REG_AW-1:0]   iInstr;
  logic [7:0]              oLed;
  logic                    oLcdValid;
  logic [7:0]              oLcdData;
  logic                    iLcdReady;
  logic                    oFault;
  logic                    oRetire;

  modport master (
    input  iEnable, iInstr, iLcdReady,
    output oIAddr, oLed, oLcdValid, oLcdData, oFault, oRetire
  );

  modport slave (
    output iEnable, iInstr, iLcdReady,
    input  oIAddr, oLed, oLcdValid, oLcdData, oFault, oRetire
  );
endinterface

// File: rtl/mini_alu_core.sv
// rtl/mini_alu_core.sv - multi-cycle fetch/execute mini ALU core
//
// Purpose: FETCH/EXEC core with an internal register file, a hardware stack
// shared by CALL/RET and PUSH/POP, an LCD byte handshake and an optional
// iterative shift-add multiplier enabled by defining MINI_ALU_MUL_EN.
//
// Ports:
//   Clock  system clock, rising edge
//   Reset  asynchronous, active-high reset
//   bus    mini_alu_core_if.master (fetch, LCD, LED, fault and retire signals)
module mini_alu_core #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_AW      = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  mini_alu_core_if.master  bus
);

  localparam int IW     = 4 + 3*REG_AW;
  localparam int SW     = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int SIDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W   = SIDX_W + 1;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MUL, S_LCDW, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d, ip_inc;
  logic [IW-1:0]     ir_q, ir_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [7:0]        led_q, led_d;
  logic              lcd_valid_q, lcd_valid_d;
  logic [7:0]        lcd_data_q, lcd_data_d;
  logic              fault_q, fault_d;
  logic              retire_q, retire_d;

  logic [3:0]        op;
  logic [REG_AW-1:0] dst, src1, src0;
  logic [DATA_W-1:0] rs1, rs0;

  // Register file and stack are plain storage without reset.
  logic [DATA_W-1:0] rf_q [2**REG_AW];
  logic [SW-1:0]     stack_q [STACK_DEPTH];
  logic [SW-1:0]     stack_top;
  logic              stack_full, stack_empty;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wd;
  logic              push;
  logic [SW-1:0]     push_data;

`ifdef MINI_ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  assign {op, dst, src1, src0} = ir_q;
  assign rs1         = rf_q[src1];
  assign rs0         = rf_q[src0];
  assign ip_inc      = ip_q + 1'b1;
  assign stack_top   = stack_q[SIDX_W'(sp_q - 1'b1)];
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    ir_d        = ir_q;
    sp_d        = sp_q;
    led_d       = led_q;
    lcd_valid_d = lcd_valid_q;
    lcd_data_d  = lcd_data_q;
    fault_d     = fault_q;
    retire_d    = 1'b0;
    rf_we       = 1'b0;
    rf_wd       = '0;
    push        = 1'b0;
    push_data   = '0;
`ifdef MINI_ALU_MUL_EN
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (bus.iEnable) begin
          ir_d    = bus.iInstr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_FETCH;
        ip_d     = ip_inc;
        retire_d = 1'b1;
        case (op)
          4'h1: led_d = rs1[7:0];
          4'h2: if (rs1 <= rs0) ip_d = ADDR_W'(dst);
          4'h3: begin rf_we = 1'b1; rf_wd = DATA_W'({src1, src0}); end
          4'h4: begin rf_we = 1'b1; rf_wd = rs1 + rs0; end
          4'h5: ip_d = ADDR_W'(dst);
          4'h6: begin rf_we = 1'b1; rf_wd = rs1 - rs0; end
`ifdef MINI_ALU_MUL_EN
          4'h7: begin
            state_d  = S_MUL;
            ip_d     = ip_q;
            retire_d = 1'b0;
            acc_d    = '0;
            mcand_d  = rs1;
            mplier_d = rs0;
            cnt_d    = '0;
          end
`endif
          4'h8, 4'hA: begin
            if (stack_full) begin
              state_d  = S_FAULT;
              fault_d  = 1'b1;
              ip_d     = ip_q;
              retire_d = 1'b0;
            end else begin
              push      = 1'b1;
              sp_d      = sp_q + 1'b1;
              // CALL pushes the return address, PUSH the source register.
              push_data = (op == 4'h8) ? SW'(ip_inc) : SW'(rs0);
              if (op == 4'h8) ip_d = ADDR_W'(dst);
            end
          end
          4'h9, 4'hB: begin
            if (stack_empty) begin
              state_d  = S_FAULT;
              fault_d  = 1'b1;
              ip_d     = ip_q;
              retire_d = 1'b0;
            end else begin
              sp_d = sp_q - 1'b1;
              if (op == 4'h9) begin
                ip_d = ADDR_W'(stack_top);
              end else begin
                rf_we = 1'b1;
                rf_wd = DATA_W'(stack_top);
              end
            end
          end
          4'hC: begin
            lcd_data_d  = rs1[7:0];
            lcd_valid_d = 1'b1;
            state_d     = S_LCDW;
            ip_d        = ip_q;
            retire_d    = 1'b0;
          end
          default: ;
        endcase
      end
`ifdef MINI_ALU_MUL_EN
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          rf_we    = 1'b1;
          rf_wd    = acc_sum;
          ip_d     = ip_inc;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
`endif
      S_LCDW: begin
        if (bus.iLcdReady) begin
          lcd_valid_d = 1'b0;
          retire_d    = 1'b1;
          ip_d        = ip_inc;
          state_d     = S_FETCH;
        end
      end
      S_FAULT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_FETCH;
      ip_q        <= '0;
      ir_q        <= '0;
      sp_q        <= '0;
      led_q       <= '0;
      lcd_valid_q <= 1'b0;
      lcd_data_q  <= '0;
      fault_q     <= 1'b0;
      retire_q    <= 1'b0;
`ifdef MINI_ALU_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      ir_q        <= ir_d;
      sp_q        <= sp_d;
      led_q       <= led_d;
      lcd_valid_q <= lcd_valid_d;
      lcd_data_q  <= lcd_data_d;
      fault_q     <= fault_d;
      retire_q    <= retire_d;
`ifdef MINI_ALU_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Writes are suppressed while Reset is high so an aborted instruction
  // leaves no trace in the register file or stack.
  always_ff @(posedge Clock) begin
    if (rf_we && !Reset) rf_q[dst] <= rf_wd;
    if (push && !Reset)  stack_q[SIDX_W'(sp_q)] <= push_data;
  end

  assign bus.oIAddr    = ip_q;
  assign bus.oLed      = led_q;
  assign bus.oLcdValid = lcd_valid_q;
  assign bus.oLcdData  = lcd_data_q;
  assign bus.oFault    = fault_q;
  assign bus.oRetire   = retire_q;

endmodule
